count_seq_monitor: RTL and testbench

//  Downstream checker for the 4-bit synchronous up-counter: samples its count

---
 rtl/count_seq_monitor.sv | 167 ++++++++++++++++
 tb/tb_count_seq_monitor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_monitor.sv
// Checker for a free-running up-counter: locks onto the +1 sequence, pulses and tallies
// MAX->0 wraps, and latches illegal jumps. Optional irq output under COUNT_MON_IRQ_EN.
module count_seq_monitor #(
  parameter int WIDTH  = 4,
  parameter int LOCK_N = 2,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4
`ifdef COUNT_MON_IRQ_EN
  , parameter int IRQ_WRAPS = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  count,
  input  logic              clr,
  output logic              tc_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              locked,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt
`ifdef COUNT_MON_IRQ_EN
  , output logic            irq
`endif
);

  localparam int RUN_W = $clog2(LOCK_N + 1);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   prev_r;
  logic [RUN_W-1:0]   run_r, run_s, run_inc_s;
  logic               primed_r;
  logic               good_s, prev_max_s, count_zero_s;
  logic               tc_s, locked_s, err_s;
  logic [WRAP_W-1:0]  wrap_s;
  logic [ERR_W-1:0]   err_cnt_s;
  logic [WIDTH-1:0]   prev_inc_s;

  function automatic logic [WRAP_W-1:0] sat_inc_wrap(input logic [WRAP_W-1:0] v);
    return (&v) ? v : v + WRAP_W'(1);
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  assign prev_inc_s   = prev_r + WIDTH'(1);
  assign good_s       = (count == prev_inc_s);
  assign prev_max_s   = (prev_r == {WIDTH{1'b1}});
  assign count_zero_s = (count == {WIDTH{1'b0}});
  assign run_inc_s    = run_r + RUN_W'(1);

  // Next-state and next-output decode; clr overrides everything except reset.
  always_comb begin
    state_s   = state_r;
    run_s     = run_r;
    tc_s      = 1'b0;
    wrap_s    = wrap_cnt;
    err_s     = err;
    err_cnt_s = err_cnt;
    if (clr) begin
      state_s   = SYNC;
      run_s     = {RUN_W{1'b0}};
      wrap_s    = {WRAP_W{1'b0}};
      err_s     = 1'b0;
      err_cnt_s = {ERR_W{1'b0}};
    end else if (!primed_r) begin
      // first edge after reset only captures prev
      state_s = SYNC;
    end else begin
      case (state_r)
        SYNC: begin
          if (good_s) begin
            run_s = run_inc_s;
            if (run_inc_s == RUN_W'(LOCK_N)) begin
              state_s = TRACK;
            end else begin
              state_s = SYNC;
            end
          end else begin
            run_s = {RUN_W{1'b0}};
          end
        end
        TRACK: begin
          if (good_s) begin
            if (prev_max_s) begin
              tc_s   = 1'b1;
              wrap_s = sat_inc_wrap(wrap_cnt);
            end else begin
              tc_s = 1'b0;
            end
          end else if (count_zero_s) begin
            state_s = SYNC;
            run_s   = {RUN_W{1'b0}};
          end else begin
            state_s   = FAULT;
            err_s     = 1'b1;
            err_cnt_s = sat_inc_err(err_cnt);
          end
        end
        FAULT: begin
          state_s = FAULT;
        end
        default: begin
          state_s = SYNC;
          run_s   = {RUN_W{1'b0}};
        end
      endcase
    end
    locked_s = (state_s == TRACK);
  end

`ifdef COUNT_MON_IRQ_EN
  logic irq_s;

  // irq is sticky: set on reaching the wrap threshold or on a new error.
  always_comb begin
    if (clr) begin
      irq_s = 1'b0;
    end else if (((wrap_s != wrap_cnt) && (wrap_s == WRAP_W'(IRQ_WRAPS))) || (err_s && !err)) begin
      irq_s = 1'b1;
    end else begin
      irq_s = irq;
    end
  end

  // irq register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_s;
    end
  end
`endif

  // State, history and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= SYNC;
      prev_r   <= {WIDTH{1'b0}};
      run_r    <= {RUN_W{1'b0}};
      primed_r <= 1'b0;
      tc_pulse <= 1'b0;
      wrap_cnt <= {WRAP_W{1'b0}};
      locked   <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= {ERR_W{1'b0}};
    end else begin
      state_r  <= state_s;
      prev_r   <= count;
      run_r    <= run_s;
      primed_r <= 1'b1;
      tc_pulse <= tc_s;
      wrap_cnt <= wrap_s;
      locked   <= locked_s;
      err      <= err_s;
      err_cnt  <= err_cnt_s;
    end
  end

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed bench: default instance plus a WRAP_W=2 instance for saturation; irq checked
// when COUNT_MON_IRQ_EN is defined.
module tb_count_seq_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr;
  logic [3:0] count;

  logic       tc_a, lk_a, err_a;
  logic [7:0] wrap_a;
  logic [3:0] errc_a;
  logic       tc_b, lk_b, err_b;
  logic [1:0] wrap_b;
  logic [3:0] errc_b;
`ifdef COUNT_MON_IRQ_EN
  logic       irq_a, irq_b;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  count_seq_monitor #(
    .WIDTH(4), .LOCK_N(2), .WRAP_W(8), .ERR_W(4)
`ifdef COUNT_MON_IRQ_EN
    , .IRQ_WRAPS(2)
`endif
  ) u_dut (
    .clk(clk), .reset(reset), .count(count), .clr(clr),
    .tc_pulse(tc_a), .wrap_cnt(wrap_a), .locked(lk_a), .err(err_a), .err_cnt(errc_a)
`ifdef COUNT_MON_IRQ_EN
    , .irq(irq_a)
`endif
  );

  count_seq_monitor #(
    .WIDTH(4), .LOCK_N(2), .WRAP_W(2), .ERR_W(4)
`ifdef COUNT_MON_IRQ_EN
    , .IRQ_WRAPS(2)
`endif
  ) u_sat (
    .clk(clk), .reset(reset), .count(count), .clr(clr),
    .tc_pulse(tc_b), .wrap_cnt(wrap_b), .locked(lk_b), .err(err_b), .err_cnt(errc_b)
`ifdef COUNT_MON_IRQ_EN
    , .irq(irq_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] c);
    count = c;
    @(posedge clk);
    #1;
  endtask

  // Walk a contiguous range; no wrap inside, so tc must stay low.
  task automatic walk(input int from, input int to, input logic exp_lk);
    for (int v = from; v <= to; v++) begin
      step(4'(v));
      check("walk_tc_a", {31'd0, tc_a}, 32'd0);
      check("walk_tc_b", {31'd0, tc_b}, 32'd0);
      check("walk_lk_a", {31'd0, lk_a}, {31'd0, exp_lk});
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tc"},   {31'd0, tc_a},  32'd0);
    check({tag, "_wrap"}, {24'd0, wrap_a}, 32'd0);
    check({tag, "_lk"},   {31'd0, lk_a},  32'd0);
    check({tag, "_err"},  {31'd0, err_a}, 32'd0);
    check({tag, "_errc"}, {28'd0, errc_a}, 32'd0);
    check({tag, "_wrapb"}, {30'd0, wrap_b}, 32'd0);
    check({tag, "_lkb"},  {31'd0, lk_b},  32'd0);
`ifdef COUNT_MON_IRQ_EN
    check({tag, "_irq"},  {31'd0, irq_a}, 32'd0);
`endif
  endtask

  initial begin
    reset = 1'b0;
    clr   = 1'b0;
    count = 4'd0;
    #12;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // lock-in and first wrap
    step(4'd0);  check("lk_load", {31'd0, lk_a}, 32'd0);
    step(4'd1);  check("lk_run1", {31'd0, lk_a}, 32'd0);
    step(4'd2);  check("lk_run2", {31'd0, lk_a}, 32'd1);
    check("lk_run2_b", {31'd0, lk_b}, 32'd1);
    walk(3, 15, 1'b1);
    step(4'd0);
    check("wrap1_tc_a", {31'd0, tc_a}, 32'd1);
    check("wrap1_tc_b", {31'd0, tc_b}, 32'd1);
    check("wrap1_cnt_a", {24'd0, wrap_a}, 32'd1);
    check("wrap1_cnt_b", {30'd0, wrap_b}, 32'd1);
`ifdef COUNT_MON_IRQ_EN
    check("wrap1_irq", {31'd0, irq_a}, 32'd0);
`endif

    // wraps 2..5: 2-bit counter saturates at 3
    for (int n = 2; n <= 5; n++) begin
      walk(1, 15, 1'b1);
      step(4'd0);
      check("wrapn_tc_a", {31'd0, tc_a}, 32'd1);
      check("wrapn_tc_b", {31'd0, tc_b}, 32'd1);
      check("wrapn_cnt_a", {24'd0, wrap_a}, 32'(n));
      check("wrapn_cnt_b", {30'd0, wrap_b}, (n > 3) ? 32'd3 : 32'(n));
`ifdef COUNT_MON_IRQ_EN
      check("wrapn_irq", {31'd0, irq_a}, 32'd1);
`endif
    end

    // illegal jump 5->9
    walk(1, 5, 1'b1);
    step(4'd9);
    check("jump_err", {31'd0, err_a}, 32'd1);
    check("jump_errc", {28'd0, errc_a}, 32'd1);
    check("jump_lk", {31'd0, lk_a}, 32'd0);
    check("jump_err_b", {31'd0, err_b}, 32'd1);
    walk(10, 15, 1'b0);
    step(4'd0);
    check("fault_tc", {31'd0, tc_a}, 32'd0);
    check("fault_wrap", {24'd0, wrap_a}, 32'd5);
    check("fault_err", {31'd0, err_a}, 32'd1);
    step(4'd1);
    check("fault_lk", {31'd0, lk_a}, 32'd0);
    clr = 1'b1;
    step(4'd2);
    clr = 1'b0;
    check("clr_err", {31'd0, err_a}, 32'd0);
    check("clr_errc", {28'd0, errc_a}, 32'd0);
    check("clr_wrap", {24'd0, wrap_a}, 32'd0);
    check("clr_lk", {31'd0, lk_a}, 32'd0);
`ifdef COUNT_MON_IRQ_EN
    check("clr_irq", {31'd0, irq_a}, 32'd0);
`endif
    step(4'd3);  check("relock1", {31'd0, lk_a}, 32'd0);
    step(4'd4);  check("relock2", {31'd0, lk_a}, 32'd1);

    // upstream restart 7->0
    walk(5, 7, 1'b1);
    step(4'd0);
    check("restart_lk", {31'd0, lk_a}, 32'd0);
    check("restart_err", {31'd0, err_a}, 32'd0);
    check("restart_errc", {28'd0, errc_a}, 32'd0);
    check("restart_tc", {31'd0, tc_a}, 32'd0);
    step(4'd1);  check("restart_run1", {31'd0, lk_a}, 32'd0);
    step(4'd2);  check("restart_run2", {31'd0, lk_a}, 32'd1);

    // clr coincident with a wrap
    walk(3, 15, 1'b1);
    step(4'd0);
    check("wrapx_tc", {31'd0, tc_a}, 32'd1);
    check("wrapx_cnt", {24'd0, wrap_a}, 32'd1);
    walk(1, 15, 1'b1);
    clr = 1'b1;
    step(4'd0);
    clr = 1'b0;
    check("clrwrap_tc", {31'd0, tc_a}, 32'd0);
    check("clrwrap_cnt", {24'd0, wrap_a}, 32'd0);
    check("clrwrap_lk", {31'd0, lk_a}, 32'd0);
    step(4'd1);  check("clrwrap_run1", {31'd0, lk_a}, 32'd0);
    step(4'd2);  check("clrwrap_run2", {31'd0, lk_a}, 32'd1);
    walk(3, 15, 1'b1);
    step(4'd0);
    check("prerst_tc", {31'd0, tc_a}, 32'd1);
    check("prerst_cnt", {24'd0, wrap_a}, 32'd1);

    // asynchronous reset between edges
    #2;
    reset = 1'b0;
    #1;
    check_zero("midreset");

    // relock after reset, then an error raises irq
    @(negedge clk);
    reset = 1'b1;
    step(4'd5);  check("rst_load", {31'd0, lk_a}, 32'd0);
    step(4'd6);  check("rst_run1", {31'd0, lk_a}, 32'd0);
    step(4'd7);  check("rst_run2", {31'd0, lk_a}, 32'd1);
    step(4'd12);
    check("err2_err", {31'd0, err_a}, 32'd1);
    check("err2_errc", {28'd0, errc_a}, 32'd1);
    check("err2_wrap", {24'd0, wrap_a}, 32'd0);
`ifdef COUNT_MON_IRQ_EN
    check("err2_irq", {31'd0, irq_a}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
